router_pkt_tx: RTL
==================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the router 1x3 input port. It accepts a packet request (dest, len) and
//  store-and-forwards len payload bytes. It then emits header, payload and parity on
//  pkt_valid/data_out, honouring the router's busy back-pressure.
//  Sits upstream of the router top; drives router pkt_valid and data_in.
// PARAMETERS
//  MAX_LEN  63  payload buffer depth in bytes; len above MAX_LEN is rejected
//  GAP      2   idle cycles (pkt_valid=0, data_out=0) after parity, before the next start
// PORTS
//  clock      in   1  system clock; all state on rising edge
//  resetn     in   1  asynchronous active-low reset
//  start      in   1  request a packet; sampled only when tx_ready=1
//  dest       in   2  destination port 0..2; 2'b11 is illegal
//  len        in   6  payload byte count 1..MAX_LEN; 0 is illegal
//  tx_ready   out  1  1 only in IDLE
//  pl_data    in   8  payload byte
//  pl_valid   in   1  pl_data valid
//  pl_ready   out  1  1 only in LOAD; a byte transfers on an edge with pl_valid & pl_ready
//  busy       in   1  router busy; while 1, the current byte on data_out is not consumed
//  pkt_valid  out  1  1 for header and payload bytes, 0 for parity byte (registered)
//  data_out   out  8  byte to router data_in (registered)
//  done       out  1  one-cycle pulse on the cycle after the parity byte is consumed
//  err        out  1  one-cycle pulse on the cycle after an illegal start
// BEHAVIOUR
//  Reset: state=IDLE; pkt_valid=0, data_out=0, done=0, err=0, counters=0, parity=0.
//   Buffer contents are don't-care. Reset mid-packet aborts immediately with no partial parity.
//  Consumed: a byte on data_out is consumed at each rising edge where busy=0 in
//   HEADER/PAYLOAD/PARITY. With busy=1, pkt_valid and data_out hold unchanged (no duplicate, no skip).
//  States:
//   IDLE: tx_ready=1. On start:
//    - illegal (dest==3, len==0 or len>MAX_LEN): err pulses next cycle; stay IDLE.
//    - legal: latch dest and len, clear wr_cnt, go to LOAD.
//   LOAD: pl_ready=1. Each transfer writes buf[wr_cnt] and increments wr_cnt.
//    pl_valid gaps are allowed. When the len-th byte transfers, go to HEADER.
//    On that edge load data_out={len,dest}, pkt_valid=1, parity={len,dest}.
//   HEADER: when the header is consumed, load data_out=buf[0], rd_cnt=1, and go to PAYLOAD.
//   PAYLOAD: on each consumed byte, parity^=data_out.
//    - If rd_cnt<len: data_out=buf[rd_cnt], rd_cnt++.
//    - Else: pkt_valid=0, data_out=parity^data_out (final parity), go to PARITY.
//   PARITY: when consumed, data_out=0, done pulses, load gap counter, go to GAP.
//   GAP: count GAP cycles with pkt_valid=0, then return to IDLE.
//  Parity = header XOR all payload bytes (8-bit, bitwise).
//  start outside IDLE is ignored. pl_valid outside LOAD is ignored.
//  busy is ignored in IDLE, LOAD and GAP.
//  Latency with busy=0: header appears 1 cycle after the last payload transfer.
//   Then 1 byte per cycle; parity follows the last payload byte by 1 cycle.
//  len=1: HEADER, one PAYLOAD byte, then PARITY. The full path is exercised; no special case.
// TESTING
//  T1 reset: assert resetn=0 mid-PAYLOAD -> pkt_valid=0, data_out=0 asynchronously.
//   After release, tx_ready=1 and no done pulse.
//  T2 basic: dest=01, len=3, payload A1,B2,C3, busy=0.
//   -> data_out 0D,A1,B2,C3 with pkt_valid=1, then DD with pkt_valid=0; done 1 cycle later.
//  T3 back-pressure: as T2 but busy=1 for 2 cycles while B2 is presented.
//   -> B2 held 3 cycles, C3 follows once, parity still DD.
//  T4 illegal: start with dest=11, then with len=0 -> err pulse each time.
//   tx_ready stays 1, pkt_valid never rises, pl_ready stays 0.
//  T5 max/gaps: dest=10, len=63, pl_valid toggling 1-0 during LOAD -> header FE,
//   63 bytes in order, parity = FE XOR payload (checked by model).
//  T6 overlap: start pulsed during PAYLOAD is ignored. A start on the first IDLE cycle
//   after the GAP=2 cycles is accepted; pkt_valid stays 0 during the gap.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: store-and-forward packet source for the router input port.
// A legal request (dest, len) first buffers len payload bytes. It then emits
// a header {len,dest}, the payload and a trailing parity byte on
// pkt_valid/data_out, stalling on busy. After the parity byte it idles for
// GAP cycles before the next request is accepted.
module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int GAP     = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  output logic       tx_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  // One bit wider than len so the upper-bound check is not constant by width
  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);

  state_t     state, state_n;
  logic [1:0] dest_q, dest_n;
  logic [5:0] len_q, len_n;
  logic [5:0] wr_cnt, wr_cnt_n;
  logic [5:0] rd_cnt, rd_cnt_n;
  logic [7:0] parity, parity_n;
  logic [7:0] data_q, data_n;
  logic       valid_q, valid_n;
  logic       done_q, done_n;
  logic       err_q, err_n;
  logic [7:0] gap_cnt, gap_cnt_n;

  logic [7:0] buf_mem [0:MAX_LEN-1];

  logic illegal_req;
  logic pl_fire;

  assign illegal_req = (dest == 2'b11) || (len == 6'd0) || ({1'b0, len} > MAX_LEN_W);
  assign pl_fire     = (state == S_LOAD) && pl_valid;

  assign tx_ready  = (state == S_IDLE);
  assign pl_ready  = (state == S_LOAD);
  assign pkt_valid = valid_q;
  assign data_out  = data_q;
  assign done      = done_q;
  assign err       = err_q;

  // Payload buffer: contents are don't-care after reset, so no reset here
  always_ff @(posedge clock) begin
    if (pl_fire) buf_mem[wr_cnt] <= pl_data;
  end

  // State and output registers; reset aborts any packet in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      dest_q  <= 2'd0;
      len_q   <= 6'd0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
      parity  <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      dest_q  <= dest_n;
      len_q   <= len_n;
      wr_cnt  <= wr_cnt_n;
      rd_cnt  <= rd_cnt_n;
      parity  <= parity_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      err_q   <= err_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Next-state logic; a byte on data_out only advances when busy is low
  always_comb begin
    state_n   = state;
    dest_n    = dest_q;
    len_n     = len_q;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    parity_n  = parity;
    data_n    = data_q;
    valid_n   = valid_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    gap_cnt_n = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (illegal_req) begin
            err_n = 1'b1;
          end else begin
            dest_n   = dest;
            len_n    = len;
            wr_cnt_n = 6'd0;
            state_n  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          wr_cnt_n = wr_cnt + 6'd1;
          if (wr_cnt == len_q - 6'd1) begin
            data_n   = {len_q, dest_q};
            parity_n = {len_q, dest_q};
            valid_n  = 1'b1;
            state_n  = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          data_n   = buf_mem[0];
          rd_cnt_n = 6'd1;
          state_n  = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          parity_n = parity ^ data_q;
          if (rd_cnt < len_q) begin
            data_n   = buf_mem[rd_cnt];
            rd_cnt_n = rd_cnt + 6'd1;
          end else begin
            valid_n = 1'b0;
            data_n  = parity ^ data_q;
            state_n = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          data_n    = 8'd0;
          done_n    = 1'b1;
          gap_cnt_n = 8'(GAP);
          state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
